// File: rtl/bit_serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
interface bit_serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/bit_serial_addsub.sv
// Bit-serial adder/subtractor: one full adder plus a carry flop processes
// the operands LSB first, one bit per clock, into a SIPO result register.
//
// state | meaning
// IDLE  | waiting for start; results hold last completed value
// SHIFT | one operand bit processed per cycle, WIDTH cycles total
// DONE  | result registered, done pulses; start here chains the next op
module bit_serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bit_serial_addsub_if.slave    bus
);

    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sipo;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic             load;
    logic             last_bit;
    logic             s_bit;
    logic             c_next;

    // Start is accepted only when no operation is in flight; the full adder
    // works on the current LSBs of the operand shift registers.
    always_comb begin
        load     = bus.start && ((state == IDLE) || (state == DONE));
        last_bit = (state == SHIFT) && (cnt == LAST);
        s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
        c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = load ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status decode and result outputs.
    always_comb begin
        bus.busy = (state == SHIFT);
        bus.done = (state == DONE);
        bus.sum  = sum_r;
        bus.cout = cout_r;
        bus.ovf  = ovf_r;
    end

    // Operand shift registers, carry flop, SIPO and bit counter.
    // Subtraction is a + ~b + 1, so the carry flop is preset to 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            sipo  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            a_sr  <= bus.a;
            b_sr  <= bus.sub ? ~bus.b : bus.b;
            sipo  <= '0;
            carry <= bus.sub ? 1'b1 : bus.cin;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            sipo  <= {s_bit, sipo[WIDTH-1:1]};
            carry <= c_next;
            cnt   <= cnt + CW'(1);
        end
    end

    // Results are captured only on the last bit so they stay stable while
    // the next operation is shifting. On that bit carry holds the carry into
    // the MSB and c_next the carry out of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (last_bit) begin
            sum_r  <= {s_bit, sipo[WIDTH-1:1]};
            cout_r <= c_next;
            ovf_r  <= carry ^ c_next;
        end
    end

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Scoreboard bench for bit_serial_addsub: an 8-bit instance driven by
// directed and random operations with a queue-based monitor, plus a 16-bit
// instance for the wide-operand cases.
module tb_bit_serial_addsub;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    int checks   = 0;
    int failures = 0;

    bit_serial_addsub_if #(.WIDTH(8))  bus8 ();
    bit_serial_addsub_if #(.WIDTH(16)) bus16 ();

    bit_serial_addsub #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    bit_serial_addsub #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] sum;
        bit         cout;
        bit         ovf;
        int         done_cyc;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    bit         mon_en = 1'b0;
    logic [7:0] hold_sum  = 8'h00;
    bit         hold_cout = 1'b0;
    bit         hold_ovf  = 1'b0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference: unsigned result modulo 2^w, carry from unsigned magnitude,
    // overflow from whether the true signed result fits in w bits.
    function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                  input bit sub, input bit cin,
                                  output longint unsigned s, output bit co, output bit ov);
        longint unsigned m;
        longint unsigned u;
        longint          sa;
        longint          sb;
        longint          r;
        m  = (longint'(1) << w) - 1;
        sa = (((a >> (w - 1)) & 1) != 0) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = (((b >> (w - 1)) & 1) != 0) ? longint'(b) - (longint'(1) << w) : longint'(b);
        if (sub) begin
            u  = (a - b) & m;
            co = (a >= b);
            r  = sa - sb;
        end else begin
            u  = a + b + longint'(cin);
            co = (u > m);
            u  = u & m;
            r  = sa + sb + longint'(cin);
        end
        s  = u;
        ov = (r > ((longint'(1) << (w - 1)) - 1)) || (r < -(longint'(1) << (w - 1)));
    endfunction

    // Monitor: pops expectations whenever the 8-bit DUT signals done.
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy_done_exclusive", {63'd0, bus8.busy & bus8.done}, 0);
            if (bus8.done) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    mon_e = q.pop_front();
                    check("latency", cyc, mon_e.done_cyc);
                    check("sum", bus8.sum, mon_e.sum);
                    check("cout", bus8.cout, mon_e.cout);
                    check("ovf", bus8.ovf, mon_e.ovf);
                    hold_sum  = mon_e.sum;
                    hold_cout = mon_e.cout;
                    hold_ovf  = mon_e.ovf;
                end
            end else if (bus8.busy) begin
                check("sum_stable_in_shift", {bus8.sum, bus8.cout, bus8.ovf},
                      {hold_sum, hold_cout, hold_ovf});
            end
            if (q.size() != 0 && cyc > q[0].done_cyc) begin
                checks++;
                failures++;
                $display("FAIL done_timeout actual=none required_cycle=%0d at cycle %0d", q[0].done_cyc, cyc);
                void'(q.pop_front());
            end
        end
    end

    // Called at a negedge: waits for the 8-bit DUT to accept, issues one op.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input bit sub, input bit cin);
        int              n;
        exp_t            e;
        longint unsigned s;
        bit              co;
        bit              ov;
        n = 0;
        while (bus8.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus8.busy) begin
            checks++;
            failures++;
            $display("FAIL wait_idle actual=busy required=idle at cycle %0d", cyc);
        end
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.sub   = sub;
        bus8.cin   = cin;
        model(8, a, b, sub, cin, s, co, ov);
        e.sum      = s[7:0];
        e.cout     = co;
        e.ovf      = ov;
        e.done_cyc = cyc + 1 + 8;
        q.push_back(e);
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        bus8.sub   = 1'($urandom);
        bus8.cin   = 1'($urandom);
        check("busy_after_start", {63'd0, bus8.busy}, 1);
    endtask

    task automatic drain8();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", q.size(), 0);
    endtask

    task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input bit sub, input bit cin);
        int              n;
        int              t;
        longint unsigned s;
        bit              co;
        bit              ov;
        model(16, a, b, sub, cin, s, co, ov);
        bus16.start = 1'b1;
        bus16.a     = a;
        bus16.b     = b;
        bus16.sub   = sub;
        bus16.cin   = cin;
        t = cyc + 1 + 16;
        @(negedge clk);
        bus16.start = 1'b0;
        bus16.a     = 16'($urandom);
        bus16.b     = 16'($urandom);
        n = 0;
        while (!bus16.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("w16_done_seen", {63'd0, bus16.done}, 1);
        check("w16_latency", cyc, t);
        check("w16_busy_low_at_done", {63'd0, bus16.busy}, 0);
        check("w16_sum", bus16.sum, s[15:0]);
        check("w16_cout", bus16.cout, co);
        check("w16_ovf", bus16.ovf, ov);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n       = 1'b0;
        bus8.start  = 1'b0;
        bus8.a      = '0;
        bus8.b      = '0;
        bus8.sub    = 1'b0;
        bus8.cin    = 1'b0;
        bus16.start = 1'b0;
        bus16.a     = '0;
        bus16.b     = '0;
        bus16.sub   = 1'b0;
        bus16.cin   = 1'b0;
        repeat (3) @(negedge clk);
        // Reset overrides a simultaneous start.
        bus8.start = 1'b1;
        @(negedge clk);
        check("reset_state", {bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf}, 0);
        check("reset_state_w16", {bus16.busy, bus16.done, bus16.sum, bus16.cout, bus16.ovf}, 0);
        bus8.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Directed cases from the plan.
        do_op8(8'h69, 8'h34, 1'b0, 1'b0);
        drain8();
        do_op8(8'h34, 8'h69, 1'b1, 1'b0);
        do_op8(8'h69, 8'h34, 1'b1, 1'b0);
        do_op8(8'hFF, 8'h00, 1'b0, 1'b1);
        do_op8(8'h05, 8'h05, 1'b1, 1'b1);
        drain8();

        // Start pulses during SHIFT must be ignored.
        do_op8(8'h12, 8'h34, 1'b0, 1'b1);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'hAA;
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.b     = 8'h55;
        @(negedge clk);
        bus8.start = 1'b0;
        drain8();
        repeat (12) @(negedge clk);

        // Reset in the middle of SHIFT (after a nonzero result exists).
        do_op8(8'h69, 8'h34, 1'b0, 1'b0);
        drain8();
        do_op8(8'h11, 8'h22, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        check("midreset_busy", {63'd0, bus8.busy}, 0);
        check("midreset_done", {63'd0, bus8.done}, 0);
        check("midreset_sum", bus8.sum, 0);
        check("midreset_cout", {63'd0, bus8.cout}, 0);
        check("midreset_ovf", {63'd0, bus8.ovf}, 0);
        q.delete();
        hold_sum  = 8'h00;
        hold_cout = 1'b0;
        hold_ovf  = 1'b0;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (15) @(negedge clk);
        do_op8(8'h7F, 8'h01, 1'b0, 1'b0);
        drain8();

        // Random operations with random gaps; gap 0 chains back to back.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        drain8();

        // Wide instance.
        do_op16(16'h8000, 16'h0001, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (5) @(negedge clk);
        check("final_queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_serial_addsub.md
# bit_serial_addsub

Parametrised bit-serial adder/subtractor: loads two WIDTH-bit operands in parallel, processes one bit per clock (LSB first) through a single full adder and carry flip-flop, and collects the result in a serial-in/parallel-out register. Adds internal sequencing, a subtract mode, a start/busy/done handshake and overflow flags. The on-board counter removes the need for externally timed load/shift strobes. It serves as the serial arithmetic unit in the datapath labs, alongside the parallel adders.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  0 = add (a + b + cin), 1 = subtract (a - b); sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- cin  in  1  carry-in for add; ignored when sub = 1; sampled with start.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse: result valid.
- sum  out  WIDTH  registered result; holds last completed value.
- cout  out  1  final carry out (sub: 1 = no borrow).
- ovf  out  1  signed two's-complement overflow of last result.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: start = 1 -> load A shift register with a; load B shift register with b (sub = 0) or ~b (sub = 1); load carry FF with cin (sub = 0) or 1 (sub = 1); clear bit counter; go to SHIFT.
- SHIFT: each cycle:
  - s = A[0] ^ B[0] ^ c; c <= majority(A[0], B[0], c).
  - Shift A and B right by one.
  - Shift s into the SIPO at the MSB end.
  - Record the carry into the MSB position on the last bit.
  - Increment counter.
  - After WIDTH bits, go to DONE.
- On the transition into DONE, register:
  - sum <= SIPO contents.
  - cout <= final carry.
  - ovf <= carry-into-MSB XOR carry-out-of-MSB.
- DONE: done = 1 for exactly this cycle.
  - start = 1 in DONE behaves as in IDLE: back-to-back operation with no gap.
  - Otherwise go to IDLE.
- start while in SHIFT is ignored; inputs a/b/sub/cin may change freely after the start cycle.
- Arithmetic is modulo 2^WIDTH; cout and ovf carry the extra information.
- Counter width is clog2(WIDTH+1).

## Timing
- Reset: rst_n = 0 at a rising edge has these effects:
  - state = IDLE.
  - busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.
  - Internal shift registers, carry and counter cleared.
  - Reset overrides start in the same cycle.
  - Reset during SHIFT aborts the operation with no done pulse; sum keeps its reset value 0.
- Cycle numbering: edge 0 samples start.
  - busy = 1 from after edge 0 until edge WIDTH.
  - Bits 0..WIDTH-1 are processed at edges 1..WIDTH.
  - sum/cout/ovf update, and done rises, at edge WIDTH.
  - done falls at edge WIDTH+1.
- Start-to-done latency is WIDTH cycles. Back-to-back throughput is one result per WIDTH+1 cycles.
- busy and done are never high together.
- sum/cout/ovf are stable from the done edge until the next completion or reset. They are not disturbed during SHIFT.

## Test plan
- WIDTH=8: a=0x69, b=0x34, sub=0, cin=0 -> done 8 cycles after start, sum=0x9D, cout=0, ovf=1.
- WIDTH=8 subtract: a=0x34, b=0x69, sub=1 -> sum=0xCB, cout=0 (borrow), ovf=0; then a=0x69, b=0x34, sub=1 -> sum=0x35, cout=1, ovf=0.
- WIDTH=8 carry/cin: a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0; with sub=1 and cin=1, cin is ignored: a=0x05, b=0x05 -> sum=0x00, cout=1.
- Handshake: pulse start again at cycles 3 and 5 of an operation -> ignored, a single done pulse. Hold start high through DONE with new operands -> a second operation begins immediately; busy returns 1 the cycle after done.
- Reset mid-operation: rst_n=0 at cycle 4 of SHIFT -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0. No done pulse until a new start; a new start then gives a correct result.
- WIDTH=16 instance: a=0x8000, b=0x0001, sub=1 -> done 16 cycles after start, sum=0x7FFF, cout=1, ovf=1.
